seq_engine_param: RTL
=====================

// Module: seq_engine_param
// PURPOSE
//  Parametrised integer-sequence generator. One engine, WIDTH bits wide, produces one of eight sequences selected at start.
//  Terms leave on a valid/ready stream with term index, optional run length and a sticky wrap flag.
//  Sits between the pin-level mode/control decode and the output mux.
//  Successor to the fixed 8-bit free-running per-sequence generators, with length control and flow control.
// PARAMETERS
//  WIDTH  8  datapath, term and index width (>=4); all arithmetic is mod 2^WIDTH
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high; overrides every other input
//  start      in   1      pulse: latch mode/len, (re)start at term 0
//  mode       in   3      sequence select, sampled only when start=1
//  len        in   WIDTH  number of terms to emit; 0 = free-running; sampled only on start
//  out_valid  out  1      out_data/out_idx hold a term
//  out_ready  in   1      consumer accepts term when out_valid & out_ready
//  out_data   out  WIDTH  current term (mod 2^WIDTH)
//  out_idx    out  WIDTH  index of current term, 0-based, wraps mod 2^WIDTH
//  wrap       out  1      sticky: some term so far exceeded 2^WIDTH-1
//  done       out  1      len terms accepted; engine halted
// BEHAVIOUR
//  Modes (term 0 first):
//   0 SQR 0,1,4,9..;  1 POW3 1,3,9,27..;  2 TRI 0,1,3,6..;  3 FIB 1,1,2,3..
//   4 PELL 0,1,2,5,12..;  5 LUC 2,1,3,4,7..;  6 PAD 1,1,1,2,2,3,4..;  7 SYLV 2,3,7,43..
//  - SQR by increment (s += 2n+1), no multiplier.
//  - SYLV a' = a*(a-1)+1 uses a WIDTHxWIDTH multiplier.
//  - State registers hold wrapped values; the next term is computed from them.
//  States:
//   IDLE: out_valid=0, done=0.
//   RUN:  out_valid=1, presents term.
//   DONE: out_valid=0, done=1.
//  Reset (any state, next edge): IDLE; out_data=0, out_idx=0, wrap=0, done=0, out_valid=0.
//  start=1 (any state, reset=0):
//   - next cycle RUN with term 0, out_idx=0, wrap=0, done=0.
//   - Latency start->first valid = 1 cycle.
//  Handshake:
//   - out_valid&out_ready at an edge -> next cycle presents the next term, out_idx+1.
//   - 1 term/cycle when out_ready held high.
//   - out_ready=0: out_data, out_idx, wrap held stable; no term is skipped or repeated.
//  Length:
//   - len!=0 and the accepted term has out_idx==len-1 -> DONE next cycle.
//   - DONE holds until start or reset; out_data/out_idx keep the last term.
//  Wrap:
//   - Next term is computed exactly in 2*WIDTH+2 bits.
//   - If the exact value > 2^WIDTH-1, wrap=1 in the same cycle that term is presented.
//   - wrap stays 1 until start or reset.
//   - out_idx wrap-around does not affect wrap.
//  Simultaneous events:
//   - reset beats start.
//   - start beats a handshake in the same cycle: the term counts as accepted, then restart.
//  mode/len changes outside start have no effect.
// TESTING
//  T1 start mode=3 len=0, ready=1 -> data 1,1,2,3,5,8,13 idx 0..6, wrap=0, done=0
//  T2 start mode=7 len=5, ready=1 -> data 2,3,7,43,15; wrap=1 from idx4; next cycle done=1, valid=0
//  T3 start mode=2 len=0, ready toggling 1,0,0,1,0,1.. -> data 0,1,3,6 in order, stable while ready=0
//  T4 mode=6 run 4 terms, then start mode=1 len=0 -> 1 cycle later data=1 idx=0 wrap=0;
//     then 1,3,9,27,81,243,217 with wrap=1 at idx 6
//  T5 start mode=0 ready=1 -> idx15 data 225 wrap=0; idx16 data 0 wrap=1; idx17 data 33
//  T6 reset during RUN (mode 4, idx 3) with start=1 same cycle -> next cycle IDLE,
//     all outputs 0; no term emitted until a later start

Source files
------------

// File: rtl/seq_engine_param.sv
// Parametrised integer-sequence generator: eight selectable sequences streamed
// over a valid/ready output with term index, optional run length and sticky wrap flag.
module seq_engine_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_idx,
  output logic             wrap,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a term is transferred on any rising edge where out_valid and
  // out_ready are both high; while out_ready is low the presented term,
  // index and wrap flag are held unchanged.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int XW = 2 * WIDTH + 2;

  state_t           state_q, state_d;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, n_q;
  logic             wrap_q;

  logic             accept;
  logic             last_term;
  logic [XW-1:0]    exact;
  logic [XW-1:0]    ax, bx, cx, nx;
  logic [WIDTH-1:0] am1;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] init_a, init_b, init_c;

  assign accept    = (state_q == S_RUN) && out_ready;
  assign last_term = (len_q != '0) && (n_q == len_q - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start beats any handshake in the same cycle
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (accept && last_term) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  assign out_data = a_q;
  assign out_idx  = n_q;
  assign wrap     = wrap_q;

  // Seed values: a = term 0, b and c = the virtual terms before it
  always_comb begin
    init_a = '0;
    init_b = '0;
    init_c = '0;
    case (mode)
      3'd1: init_a = WIDTH'(1);
      3'd3: init_a = WIDTH'(1);
      3'd4: init_b = WIDTH'(1);
      3'd5: init_a = WIDTH'(2);
      3'd6: begin
        init_a = WIDTH'(1);
        init_c = WIDTH'(1);
      end
      3'd7: init_a = WIDTH'(2);
      default: init_a = '0;
    endcase
  end

  // Exact next term from the wrapped history, wide enough to never overflow
  always_comb begin
    ax    = XW'(a_q);
    bx    = XW'(b_q);
    cx    = XW'(c_q);
    nx    = XW'(n_q);
    am1   = a_q - 1'b1;
    prod  = (2 * WIDTH)'(a_q) * (2 * WIDTH)'(am1);
    exact = '0;
    case (mode_q)
      3'd0: exact = ax + (nx << 1) + XW'(1);
      3'd1: exact = ax + (ax << 1);
      3'd2: exact = ax + nx + XW'(1);
      3'd3: exact = ax + bx;
      3'd4: exact = (ax << 1) + bx;
      3'd5: exact = (n_q == '0) ? XW'(1) : (ax + bx);
      3'd6: exact = bx + cx;
      3'd7: exact = XW'(prod) + XW'(1);
      default: exact = '0;
    endcase
  end

  // Datapath; on the final accepted term the last value is kept for DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      len_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      n_q    <= '0;
      wrap_q <= 1'b0;
    end else if (start) begin
      mode_q <= mode;
      len_q  <= len;
      a_q    <= init_a;
      b_q    <= init_b;
      c_q    <= init_c;
      n_q    <= '0;
      wrap_q <= 1'b0;
    end else if (accept && !last_term) begin
      a_q <= exact[WIDTH-1:0];
      b_q <= a_q;
      c_q <= b_q;
      n_q <= n_q + 1'b1;
      if (|exact[XW-1:WIDTH]) wrap_q <= 1'b1;
    end
  end

endmodule
